// File: rtl/pcie_cpl_tlp_arb.sv
// Packet-level round-robin arbiter sharing the TX completion TLP stream between NUM_SRC producers.
// Optional CPL_ARB_STRICT_PRIO_EN: source 0 always wins in IDLE and does not advance rr_ptr.
module pcie_cpl_tlp_arb #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned STRB_WIDTH = 8,
    parameter int unsigned HDR_WIDTH  = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tlp_data,
    input  logic [NUM_SRC*STRB_WIDTH-1:0] s_tlp_strb,
    input  logic [NUM_SRC*HDR_WIDTH-1:0]  s_tlp_hdr,
    input  logic [NUM_SRC-1:0]            s_tlp_valid,
    input  logic [NUM_SRC-1:0]            s_tlp_sop,
    input  logic [NUM_SRC-1:0]            s_tlp_eop,
    output logic [NUM_SRC-1:0]            s_tlp_ready,
    output logic [DATA_WIDTH-1:0]         tx_cpl_tlp_data,
    output logic [STRB_WIDTH-1:0]         tx_cpl_tlp_strb,
    output logic [HDR_WIDTH-1:0]          tx_cpl_tlp_hdr,
    output logic                          tx_cpl_tlp_valid,
    output logic                          tx_cpl_tlp_sop,
    output logic                          tx_cpl_tlp_eop,
    input  logic                          tx_cpl_tlp_ready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          err_no_sop,
    output logic [15:0]                   pkt_count
);

    localparam int unsigned IdW = $clog2(NUM_SRC);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [15:0]    pkt_count_q, pkt_count_d;
    logic           err_q, err_d;

    logic [NUM_SRC-1:0] cand;
    logic               have_cand;
    logic [IdW-1:0]     winner;
    logic [IdW-1:0]     drop;
    logic [IdW-1:0]     sel;
    logic               discard;
    logic               xfer;

    function automatic logic [IdW-1:0] next_src(input logic [IdW-1:0] cur);
        return (cur == IdW'(NUM_SRC - 1)) ? '0 : cur + 1'b1;
    endfunction

    function automatic logic may_advance(input logic [IdW-1:0] src);
`ifdef CPL_ARB_STRICT_PRIO_EN
        return src != '0;
`else
        return src == src;
`endif
    endfunction

    // Round-robin winner among SOP candidates and lowest-index non-SOP beat to drop.
    always_comb begin
        cand      = s_tlp_valid & s_tlp_sop;
        have_cand = 1'b0;
        winner    = '0;
        drop      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            logic [IdW-1:0] idx;
            idx = IdW'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!have_cand && cand[idx]) begin
                have_cand = 1'b1;
                winner    = idx;
            end
        end
`ifdef CPL_ARB_STRICT_PRIO_EN
        if (cand[0]) winner = '0;
`endif
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (s_tlp_valid[k]) drop = IdW'(k);
        end
    end

    always_comb begin
        sel              = grant_q;
        tx_cpl_tlp_valid = 1'b0;
        s_tlp_ready      = '0;
        discard          = 1'b0;
        if (state_q == StBusy) begin
            tx_cpl_tlp_valid     = s_tlp_valid[grant_q];
            s_tlp_ready[grant_q] = tx_cpl_tlp_ready;
        end else if (have_cand) begin
            sel                 = winner;
            tx_cpl_tlp_valid    = 1'b1;
            s_tlp_ready[winner] = tx_cpl_tlp_ready;
        end else if (|s_tlp_valid) begin
            s_tlp_ready[drop] = 1'b1;
            discard           = 1'b1;
        end
        if (!rst) begin
            tx_cpl_tlp_valid = 1'b0;
            s_tlp_ready      = '0;
            discard          = 1'b0;
        end
        tx_cpl_tlp_data = s_tlp_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
        tx_cpl_tlp_strb = s_tlp_strb[32'(sel)*STRB_WIDTH +: STRB_WIDTH];
        tx_cpl_tlp_hdr  = s_tlp_hdr[32'(sel)*HDR_WIDTH +: HDR_WIDTH];
        tx_cpl_tlp_sop  = s_tlp_sop[sel];
        tx_cpl_tlp_eop  = s_tlp_eop[sel];
        xfer            = tx_cpl_tlp_valid & tx_cpl_tlp_ready;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        pkt_count_d = pkt_count_q;
        err_d       = discard;
        if (xfer) begin
            if (state_q == StIdle) begin
                grant_d = winner;
                if (tx_cpl_tlp_eop) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    if (may_advance(winner)) rr_ptr_d = next_src(winner);
                end else begin
                    state_d = StBusy;
                end
            end else if (tx_cpl_tlp_eop) begin
                state_d     = StIdle;
                pkt_count_d = pkt_count_q + 16'd1;
                if (may_advance(grant_q)) rr_ptr_d = next_src(grant_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    assign grant_id   = grant_q;
    assign err_no_sop = err_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_pcie_cpl_tlp_arb.sv
// Bench for pcie_cpl_tlp_arb: vector table, corner-case sequences and randomized traffic
// compared against a packet-level reference model.
module tb_pcie_cpl_tlp_arb;

    localparam int N  = 2;
    localparam int DW = 256;
    localparam int SW = 8;
    localparam int HW = 128;
`ifdef CPL_ARB_STRICT_PRIO_EN
    localparam bit Strict = 1'b1;
`else
    localparam bit Strict = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] src_data [N];
    logic [SW-1:0] src_strb [N];
    logic [HW-1:0] src_hdr  [N];
    logic [N-1:0]  v, sop, eop, rdy;
    logic          txr;
    logic [N*DW-1:0] s_data;
    logic [N*SW-1:0] s_strb;
    logic [N*HW-1:0] s_hdr;
    logic [DW-1:0] tx_data;
    logic [SW-1:0] tx_strb;
    logic [HW-1:0] tx_hdr;
    logic          tx_v, tx_sop, tx_eop, err;
    logic [0:0]    gid;
    logic [15:0]   cnt;

    always #5 clk = ~clk;

    always_comb begin
        s_data = '0;
        s_strb = '0;
        s_hdr  = '0;
        for (int i = 0; i < N; i++) begin
            s_data[i*DW +: DW] = src_data[i];
            s_strb[i*SW +: SW] = src_strb[i];
            s_hdr[i*HW +: HW]  = src_hdr[i];
        end
    end

    pcie_cpl_tlp_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW)) dut (
        .clk(clk), .rst(rst),
        .s_tlp_data(s_data), .s_tlp_strb(s_strb), .s_tlp_hdr(s_hdr),
        .s_tlp_valid(v), .s_tlp_sop(sop), .s_tlp_eop(eop), .s_tlp_ready(rdy),
        .tx_cpl_tlp_data(tx_data), .tx_cpl_tlp_strb(tx_strb), .tx_cpl_tlp_hdr(tx_hdr),
        .tx_cpl_tlp_valid(tx_v), .tx_cpl_tlp_sop(tx_sop), .tx_cpl_tlp_eop(tx_eop),
        .tx_cpl_tlp_ready(txr), .grant_id(gid), .err_no_sop(err), .pkt_count(cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: packet ownership, round-robin pointer, counters.
    bit m_busy;
    int m_owner, m_ptr, m_grant, m_cnt;
    bit m_err;
    bit e_tv, e_disc, e_found;
    logic [N-1:0] e_rdy;
    int e_sel, e_win;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_grant = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_eval();
        e_tv = 0; e_rdy = '0; e_sel = m_grant; e_disc = 0; e_found = 0; e_win = 0;
        if (m_busy) begin
            e_sel = m_owner;
            e_tv = v[m_owner];
            e_rdy[m_owner] = txr;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!e_found && v[j] && sop[j]) begin e_found = 1; e_win = j; end
            end
            if (Strict && v[0] && sop[0]) e_win = 0;
            if (e_found) begin
                e_sel = e_win; e_tv = 1; e_rdy[e_win] = txr;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!e_disc && v[k]) begin e_disc = 1; e_rdy[k] = 1'b1; end
                end
            end
        end
    endtask

    task automatic model_commit();
        m_err = e_disc;
        if (e_tv && txr) begin
            if (!m_busy) begin
                m_grant = e_win;
                if (eop[e_win]) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    if (!(Strict && e_win == 0)) m_ptr = (e_win + 1) % N;
                end else begin
                    m_busy = 1; m_owner = e_win;
                end
            end else if (eop[m_owner]) begin
                m_busy = 0;
                m_cnt = (m_cnt + 1) % 65536;
                if (!(Strict && m_owner == 0)) m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < DW / 32; w++) src_data[i][w*32 +: 32] = $urandom;
            for (int w = 0; w < HW / 32; w++) src_hdr[i][w*32 +: 32] = $urandom;
            src_strb[i] = SW'($urandom);
        end
    endtask

    task automatic drive(input logic [N-1:0] vv, input logic [N-1:0] ss, input logic [N-1:0] ee,
                         input logic r);
        v = vv; sop = ss; eop = ee; txr = r;
    endtask

    task automatic sample(input bit check);
        #3;
        model_eval();
        if (check) begin
            chk("tx_valid", tx_v, e_tv);
            chk("s_ready", rdy, e_rdy);
            chk("grant_id", gid, m_grant);
            chk("pkt_count", cnt, m_cnt);
            chk("err_no_sop", err, m_err);
            if (e_tv) begin
                chk("tx_data", tx_data, src_data[e_sel]);
                chk("tx_hdr", tx_hdr, src_hdr[e_sel]);
                chk("tx_strb", tx_strb, src_strb[e_sel]);
                chk("tx_sop", tx_sop, sop[e_sel]);
                chk("tx_eop", tx_eop, eop[e_sel]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_commit();
        #1;
    endtask

    typedef struct {
        logic [N-1:0] v, sop, eop;
        logic         txr;
        logic         tv;
        logic [N-1:0] rdy;
        int           sel;
        int           gid;
        int           cnt;
        logic         err;
    } vec_t;

    vec_t tab [7];

    initial begin
        // Both sources offer 1-beat TLPs, then a non-SOP beat, then idle.
        tab[0] = '{2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 0, 0, 0, 1'b0};
        tab[1] = '{2'b11, 2'b11, 2'b11, 1'b1, 1'b1, Strict ? 2'b01 : 2'b10, Strict ? 0 : 1,
                   0, 1, 1'b0};
        tab[2] = '{2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 0, Strict ? 0 : 1, 2, 1'b0};
        tab[3] = '{2'b11, 2'b11, 2'b11, 1'b1, 1'b1, Strict ? 2'b01 : 2'b10, Strict ? 0 : 1,
                   0, 3, 1'b0};
        tab[4] = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 0, Strict ? 0 : 1, 4, 1'b0};
        tab[5] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 0, Strict ? 0 : 1, 4, 1'b1};
        tab[6] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 0, Strict ? 0 : 1, 4, 1'b0};

        rst = 1'b0;
        rand_fields();
        drive(2'b11, 2'b11, 2'b11, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_v, 1'b0);
        chk("rst_ready", rdy, 2'b00);
        chk("rst_grant", gid, 1'b0);
        chk("rst_pkt_count", cnt, 16'd0);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 7; i++) begin
            rand_fields();
            drive(tab[i].v, tab[i].sop, tab[i].eop, tab[i].txr);
            sample(1'b0);
            chk("tab_valid", tx_v, tab[i].tv);
            chk("tab_ready", rdy, tab[i].rdy);
            chk("tab_grant", gid, tab[i].gid);
            chk("tab_pkt_count", cnt, tab[i].cnt);
            chk("tab_err", err, tab[i].err);
            if (tab[i].tv) chk("tab_data", tx_data, src_data[tab[i].sel]);
            tick();
        end

        // src0 3-beat packet; src1 raises a 1-beat TLP at beat 2 and must wait.
        rand_fields(); drive(2'b01, 2'b01, 2'b00, 1'b1); sample(1'b1); tick();
        rand_fields(); drive(2'b11, 2'b10, 2'b10, 1'b1); sample(1'b1);
        chk("hold_src1_b2", rdy[1], 1'b0);
        tick();
        rand_fields(); drive(2'b11, 2'b10, 2'b11, 1'b1); sample(1'b1);
        chk("hold_src1_b3", rdy[1], 1'b0);
        chk("src0_eop_out", tx_eop, 1'b1);
        tick();
        rand_fields(); drive(2'b10, 2'b10, 2'b10, 1'b1); sample(1'b1);
        chk("src1_next", rdy, 2'b10);
        tick();

        // 4-beat src1 packet with sink ready 1,0,0,1,1,1.
        begin
            logic ready_pat [6];
            int b;
            ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            b = 0;
            for (int c = 0; c < 6; c++) begin
                rand_fields();
                src_data[1] = DW'(b + 32'h100);
                drive(2'b10, {b == 0, 1'b0}, {b == 3, 1'b0}, ready_pat[c]);
                sample(1'b1);
                chk("stall_beat", tx_data, DW'(b + 32'h100));
                tick();
                if (e_rdy[1]) b++;
            end
            chk("stall_beats_done", b, 4);
            chk("stall_pkt_count", cnt, 16'd7);
            rand_fields(); drive(2'b11, 2'b11, 2'b11, 1'b1); sample(1'b1);
            chk("rr_back_to_0", rdy, 2'b01);
            tick();
        end

        // Reset in the middle of a 4-beat src0 packet.
        rand_fields(); drive(2'b01, 2'b01, 2'b00, 1'b1); sample(1'b1); tick();
        rand_fields(); drive(2'b01, 2'b00, 2'b00, 1'b1); sample(1'b1); tick();
        rand_fields(); drive(2'b01, 2'b00, 2'b00, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_valid", tx_v, 1'b0);
        chk("midrst_ready", rdy, 2'b00);
        chk("midrst_pkt_count", cnt, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        rand_fields(); drive(2'b11, 2'b11, 2'b11, 1'b1); sample(1'b1);
        chk("post_rst_rr", rdy, 2'b01);
        chk("post_rst_grant", gid, 1'b0);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            rand_fields();
            drive(N'($urandom), N'($urandom), N'($urandom), ($urandom_range(3, 0) != 0));
            sample(1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
